// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the parametrised serial combination lock.
//   - lk_state_e : FSM state encodings, also driven onto the state debug port
//   - LK_STATE_W : width of the state encoding
//   - digit_lsb(): bit offset of digit[idx] inside a packed code word, where
//                  digit 0 is the most significant slice
package lock_pkg;

    localparam int LK_STATE_W = 3;

    typedef enum logic [LK_STATE_W-1:0] {
        LK_ENTRY    = 3'd0,
        LK_ERROR    = 3'd1,
        LK_LOCKOUT  = 3'd2,
        LK_UNLOCKED = 3'd3,
        LK_PROGRAM  = 3'd4
    } lk_state_e;

    function automatic int digit_lsb(input int idx, input int n_digits, input int digit_w);
        return (n_digits - 1 - idx) * digit_w;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter with a zero flag.
//   clk, rst_n  : clock, asynchronous active-low reset (count clears to 0)
//   i_load      : load i_load_val (takes priority over i_en)
//   i_load_val  : value loaded when i_load=1
//   i_en        : decrement by one; holds at zero
//   o_zero      : count is zero
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/lock_fsm_param.sv
// lock_fsm_param: serial combination lock with N_DIGITS digits of DIGIT_W bits.
// A wrong code is only reported after the whole code has been entered, repeated
// failures cause a timed lockout, a stalled partial entry times out, and the
// code can be reprogrammed while unlocked.
//
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-low reset
//   key_valid    : one-cycle strobe; key_digit is taken on every cycle it is 1.
//                  There is no back-pressure: a strobe arriving in a state that
//                  does not accept digits is dropped.
//   key_digit    : digit value
//   lock_cmd     : relock from UNLOCKED, abort from PROGRAM
//   prog_cmd     : enter PROGRAM from UNLOCKED
//   unlock, error, lockout, prog_mode : state decodes (error is a 1-cycle pulse)
//   digit_count  : digits taken in the current entry/program sequence
//   fail_count   : consecutive failed attempts
//   state        : raw FSM state (debug)
module lock_fsm_param
    import lock_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int DIGIT_W        = 4,
    parameter logic [N_DIGITS*DIGIT_W-1:0] RESET_CODE = 16'h1234,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int ENTRY_TIMEOUT  = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              key_valid,
    input  logic [DIGIT_W-1:0]                key_digit,
    input  logic                              lock_cmd,
    input  logic                              prog_cmd,
    output logic                              unlock,
    output logic                              error,
    output logic                              lockout,
    output logic                              prog_mode,
    output logic [$clog2(N_DIGITS+1)-1:0]     digit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0]    fail_count,
    output logic [LK_STATE_W-1:0]             state
);

    localparam int CODE_W = N_DIGITS * DIGIT_W;
    localparam int DC_W   = $clog2(N_DIGITS + 1);
    localparam int FC_W   = $clog2(MAX_TRIES + 1);
    localparam int LT_W   = $clog2(LOCKOUT_CYCLES + 1);
    localparam int ET_W   = (ENTRY_TIMEOUT > 0) ? $clog2(ENTRY_TIMEOUT + 1) : 1;

    localparam logic [DC_W-1:0] LAST_DIGIT = DC_W'(N_DIGITS - 1);
    localparam logic [FC_W-1:0] MAX_FAILS  = FC_W'(MAX_TRIES);
    // Both timers are loaded with (duration - 1) and the FSM acts on the cycle
    // the counter already reads zero, so the zero cycle is the last one counted.
    localparam logic [LT_W-1:0] LOCK_LOAD  = LT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [ET_W-1:0] ENT_LOAD   = ET_W'((ENTRY_TIMEOUT > 0) ? ENTRY_TIMEOUT - 1 : 0);

    lk_state_e          r_state, w_state_n;
    logic [DC_W-1:0]    r_digit_count, w_digit_count_n;
    logic [FC_W-1:0]    r_fail_count, w_fail_count_n;
    logic               r_mismatch, w_mismatch_n;
    logic [CODE_W-1:0]  r_code, w_code_n;
    logic [CODE_W-1:0]  r_shadow, w_shadow_n;

    logic               w_lock_load, w_lock_en, w_lock_zero;
    logic               w_ent_load, w_ent_en, w_ent_zero;
    int                 w_lsb;
    logic               w_hit;
    logic [CODE_W-1:0]  w_shadow_wr;

    assign w_lsb = digit_lsb(int'(r_digit_count), N_DIGITS, DIGIT_W);
    assign w_hit = (key_digit == r_code[w_lsb +: DIGIT_W]);

    // Shadow with the current digit written; committed whole on the last digit
    // so the live code changes in a single edge.
    always_comb begin
        w_shadow_wr = r_shadow;
        w_shadow_wr[w_lsb +: DIGIT_W] = key_digit;
    end

    lock_timer #(.W(LT_W)) u_lock_timer (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_lock_load),
        .i_load_val (LOCK_LOAD),
        .i_en       (w_lock_en),
        .o_zero     (w_lock_zero)
    );

    lock_timer #(.W(ET_W)) u_entry_timer (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_ent_load),
        .i_load_val (ENT_LOAD),
        .i_en       (w_ent_en),
        .o_zero     (w_ent_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= LK_ENTRY;
            r_digit_count <= '0;
            r_fail_count  <= '0;
            r_mismatch    <= 1'b0;
            r_code        <= RESET_CODE;
            r_shadow      <= '0;
        end else begin
            r_state       <= w_state_n;
            r_digit_count <= w_digit_count_n;
            r_fail_count  <= w_fail_count_n;
            r_mismatch    <= w_mismatch_n;
            r_code        <= w_code_n;
            r_shadow      <= w_shadow_n;
        end
    end

    always_comb begin
        w_state_n       = r_state;
        w_digit_count_n = r_digit_count;
        w_fail_count_n  = r_fail_count;
        w_mismatch_n    = r_mismatch;
        w_code_n        = r_code;
        w_shadow_n      = r_shadow;
        w_lock_load     = 1'b0;
        w_lock_en       = 1'b0;
        w_ent_load      = 1'b0;
        w_ent_en        = 1'b0;

        case (r_state)
            LK_ENTRY: begin
                if (key_valid) begin
                    w_ent_load = 1'b1;
                    if (r_digit_count == LAST_DIGIT) begin
                        w_digit_count_n = '0;
                        w_mismatch_n    = 1'b0;
                        if (!r_mismatch && w_hit) begin
                            w_state_n      = LK_UNLOCKED;
                            w_fail_count_n = '0;
                        end else begin
                            w_state_n = LK_ERROR;
                        end
                    end else begin
                        w_digit_count_n = r_digit_count + 1'b1;
                        if (!w_hit) begin
                            w_mismatch_n = 1'b1;
                        end
                    end
                end else if ((ENTRY_TIMEOUT > 0) && (r_digit_count != '0)) begin
                    // Silent discard of a stalled entry; not counted as a failure.
                    if (w_ent_zero) begin
                        w_digit_count_n = '0;
                        w_mismatch_n    = 1'b0;
                    end else begin
                        w_ent_en = 1'b1;
                    end
                end
            end

            LK_ERROR: begin
                w_fail_count_n = (r_fail_count >= MAX_FAILS) ? MAX_FAILS : r_fail_count + 1'b1;
                if (w_fail_count_n == MAX_FAILS) begin
                    w_state_n   = LK_LOCKOUT;
                    w_lock_load = 1'b1;
                end else begin
                    w_state_n = LK_ENTRY;
                end
            end

            LK_LOCKOUT: begin
                if (w_lock_zero) begin
                    w_state_n      = LK_ENTRY;
                    w_fail_count_n = '0;
                end else begin
                    w_lock_en = 1'b1;
                end
            end

            LK_UNLOCKED: begin
                if (lock_cmd) begin
                    w_state_n = LK_ENTRY;
                end else if (prog_cmd) begin
                    w_state_n       = LK_PROGRAM;
                    w_digit_count_n = '0;
                end
            end

            LK_PROGRAM: begin
                // Abort beats a simultaneous final digit: the code stays as it was.
                if (lock_cmd) begin
                    w_state_n       = LK_ENTRY;
                    w_digit_count_n = '0;
                end else if (key_valid) begin
                    w_shadow_n = w_shadow_wr;
                    if (r_digit_count == LAST_DIGIT) begin
                        w_code_n        = w_shadow_wr;
                        w_digit_count_n = '0;
                        w_state_n       = LK_UNLOCKED;
                    end else begin
                        w_digit_count_n = r_digit_count + 1'b1;
                    end
                end
            end

            default: begin
                w_state_n       = LK_ENTRY;
                w_digit_count_n = '0;
                w_mismatch_n    = 1'b0;
            end
        endcase
    end

    assign unlock      = (r_state == LK_UNLOCKED);
    assign error       = (r_state == LK_ERROR);
    assign lockout     = (r_state == LK_LOCKOUT);
    assign prog_mode   = (r_state == LK_PROGRAM);
    assign digit_count = r_digit_count;
    assign fail_count  = r_fail_count;
    assign state       = r_state;

endmodule

// File: tb/tb_lock_fsm_param.sv
// Directed bench for lock_fsm_param with default parameters (code 1,2,3,4).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_lock_fsm_param;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       lock_cmd;
    logic       prog_cmd;
    logic       unlock;
    logic       error;
    logic       lockout;
    logic       prog_mode;
    logic [2:0] digit_count;
    logic [1:0] fail_count;
    logic [2:0] state;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [2:0] S_ENTRY = 3'd0, S_ERROR = 3'd1, S_LOCKOUT = 3'd2,
                           S_UNLOCKED = 3'd3, S_PROGRAM = 3'd4;

    lock_fsm_param dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .lock_cmd    (lock_cmd),
        .prog_cmd    (prog_cmd),
        .unlock      (unlock),
        .error       (error),
        .lockout     (lockout),
        .prog_mode   (prog_mode),
        .digit_count (digit_count),
        .fail_count  (fail_count),
        .state       (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_digit = 4'h0;
    endtask

    task automatic press_code(input logic [15:0] code);
        press(code[15:12]);
        press(code[11:8]);
        press(code[7:4]);
        press(code[3:0]);
    endtask

    task automatic do_lock();
        lock_cmd = 1'b1;
        @(posedge clk);
        #1;
        lock_cmd = 1'b0;
    endtask

    task automatic do_prog();
        prog_cmd = 1'b1;
        @(posedge clk);
        #1;
        prog_cmd = 1'b0;
    endtask

    // checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [2:0] dc,
                             input logic [1:0] fc);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".unlock"}, 32'(unlock), 32'(st == S_UNLOCKED));
        check({tag, ".error"}, 32'(error), 32'(st == S_ERROR));
        check({tag, ".lockout"}, 32'(lockout), 32'(st == S_LOCKOUT));
        check({tag, ".prog_mode"}, 32'(prog_mode), 32'(st == S_PROGRAM));
        check({tag, ".digit_count"}, 32'(digit_count), 32'(dc));
        check({tag, ".fail_count"}, 32'(fail_count), 32'(fc));
    endtask

    initial begin
        reset     = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'h0;
        lock_cmd  = 1'b0;
        prog_cmd  = 1'b0;
        tick(3);
        check_all("reset", S_ENTRY, 3'd0, 2'd0);
        reset = 1'b1;
        tick(1);

        // 1: correct code
        press(4'h1); press(4'h2); press(4'h3);
        check_all("t1_partial", S_ENTRY, 3'd3, 2'd0);
        press(4'h4);
        check_all("t1_unlock", S_UNLOCKED, 3'd0, 2'd0);
        do_lock();
        check_all("t1_relock", S_ENTRY, 3'd0, 2'd0);

        // 2: wrong second digit, failure only after the 4th digit
        press(4'h1); press(4'h9);
        check_all("t2_no_leak", S_ENTRY, 3'd2, 2'd0);
        press(4'h3); press(4'h4);
        check_all("t2_error", S_ERROR, 3'd0, 2'd0);
        tick(1);
        check_all("t2_back", S_ENTRY, 3'd0, 2'd1);

        // clear fail_count with a good code
        press_code(16'h1234);
        check_all("t3_pre_unlock", S_UNLOCKED, 3'd0, 2'd0);
        do_lock();

        // 3: three wrong codes -> lockout of 16 cycles
        press_code(16'h1111); tick(1);
        check_all("t3_fail1", S_ENTRY, 3'd0, 2'd1);
        press_code(16'h4321); tick(1);
        check_all("t3_fail2", S_ENTRY, 3'd0, 2'd2);
        press_code(16'h1235);
        check_all("t3_err3", S_ERROR, 3'd0, 2'd2);
        tick(1);
        check_all("t3_lock_c1", S_LOCKOUT, 3'd0, 2'd3);
        press_code(16'h1234);                 // lockout cycles 2..5, ignored
        check_all("t3_lock_c5", S_LOCKOUT, 3'd0, 2'd3);
        tick(11);
        check_all("t3_lock_c16", S_LOCKOUT, 3'd0, 2'd3);
        tick(1);
        check_all("t3_lock_done", S_ENTRY, 3'd0, 2'd0);
        press_code(16'h1234);
        check_all("t3_unlock", S_UNLOCKED, 3'd0, 2'd0);
        do_lock();

        // 4: entry timeout with one failure on record
        press_code(16'h0000); tick(1);
        check_all("t4_fail1", S_ENTRY, 3'd0, 2'd1);
        press(4'h1); press(4'h2);
        tick(31);
        check_all("t4_idle31", S_ENTRY, 3'd2, 2'd1);
        tick(1);
        check_all("t4_idle32", S_ENTRY, 3'd0, 2'd1);
        press_code(16'h1234);
        check_all("t4_unlock", S_UNLOCKED, 3'd0, 2'd0);

        // 5: reprogram to 5,6,7,8
        do_prog();
        check_all("t5_prog", S_PROGRAM, 3'd0, 2'd0);
        press(4'h5); press(4'h6); press(4'h7);
        check_all("t5_prog3", S_PROGRAM, 3'd3, 2'd0);
        press(4'h8);
        check_all("t5_prog_done", S_UNLOCKED, 3'd0, 2'd0);
        do_lock();
        check_all("t5_relock", S_ENTRY, 3'd0, 2'd0);
        press_code(16'h1234);
        check_all("t5_old_code", S_ERROR, 3'd0, 2'd0);
        tick(1);
        press_code(16'h5678);
        check_all("t5_new_code", S_UNLOCKED, 3'd0, 2'd0);
        do_lock();

        // 6b: asynchronous reset mid-entry restores RESET_CODE
        press(4'h5); press(4'h6);
        check_all("t6_pre_reset", S_ENTRY, 3'd2, 2'd0);
        #2;
        reset = 1'b0;
        #1;
        check_all("t6_async_reset", S_ENTRY, 3'd0, 2'd0);
        tick(1);
        reset = 1'b1;
        tick(1);
        press_code(16'h1234);
        check_all("t6_reset_code", S_UNLOCKED, 3'd0, 2'd0);

        // 6a: programming aborted after two digits
        do_prog();
        press(4'h5); press(4'h6);
        check_all("t6_prog2", S_PROGRAM, 3'd2, 2'd0);
        do_lock();
        check_all("t6_abort", S_ENTRY, 3'd0, 2'd0);
        press_code(16'h1234);
        check_all("t6_code_kept", S_UNLOCKED, 3'd0, 2'd0);

        // lock_cmd together with the final program digit: abort wins
        do_prog();
        press(4'h9); press(4'h9); press(4'h9);
        lock_cmd = 1'b1;
        press(4'h9);
        lock_cmd = 1'b0;
        check_all("t6_abort_final", S_ENTRY, 3'd0, 2'd0);
        press_code(16'h1234);
        check_all("t6_abort_final_code", S_UNLOCKED, 3'd0, 2'd0);

        // lock_cmd beats prog_cmd in UNLOCKED
        lock_cmd = 1'b1;
        prog_cmd = 1'b1;
        tick(1);
        lock_cmd = 1'b0;
        prog_cmd = 1'b0;
        check_all("t6_lock_beats_prog", S_ENTRY, 3'd0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lock_fsm_param.md
Name: lock_fsm_param

Overview:
Parametrised successor to the three-bit serial combination lock. Accepts a code of N_DIGITS digits, each DIGIT_W bits wide, entered one digit per strobe. Adds the following behaviour:
- failure only reported after the full code is entered (no early leak);
- failed-attempt counter with timed lockout;
- entry inactivity timeout;
- in-field reprogramming of the code while unlocked.

Sits between the keypad front-end and the door actuator/status logic.

Parameters:
N_DIGITS, 4, digits per code (>=1)
DIGIT_W, 4, bits per digit
RESET_CODE, 16'h1234, code loaded at reset; width N_DIGITS*DIGIT_W; digit 0 = most significant slice
MAX_TRIES, 3, consecutive failures that trigger lockout (>=1)
LOCKOUT_CYCLES, 16, lockout duration in clk cycles (>=1)
ENTRY_TIMEOUT, 32, idle cycles after a partial entry before it is discarded; 0 disables

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
key_valid  in  1  one-cycle strobe, digit present on key_digit
key_digit  in  DIGIT_W  digit value, sampled when key_valid=1
lock_cmd  in  1  relock request; also aborts programming
prog_cmd  in  1  enter programming mode (honoured only when unlocked)
unlock  out  1  high while in UNLOCKED
error  out  1  one-cycle pulse per failed attempt
lockout  out  1  high while in LOCKOUT
prog_mode  out  1  high while in PROGRAM
digit_count  out  $clog2(N_DIGITS+1)  digits taken in the current entry/program sequence
fail_count  out  $clog2(MAX_TRIES+1)  consecutive failed attempts
state  out  3  ENTRY=0, ERROR=1, LOCKOUT=2, UNLOCKED=3, PROGRAM=4

Behaviour:
Reset and timing:
- Reset (reset=0, async): state=ENTRY, code_reg=RESET_CODE, digit_count=0, fail_count=0, mismatch flag=0, timers=0. All outputs are 0.
- All outputs decode from registered state/counters; none are combinational from inputs.
- Reset mid-operation discards partial entry, lockout and programming; any reprogrammed code is lost.

ENTRY:
- On key_valid, compare key_digit with code_reg digit[digit_count].
- On a miss, set the sticky mismatch flag.
- Increment digit_count.
- On the N_DIGITS-th key_valid:
  - full match -> UNLOCKED next cycle; fail_count:=0.
  - otherwise -> ERROR.
  - In both cases digit_count:=0 and mismatch:=0.
- Latency: unlock=1 in the cycle after the final key_valid.
- Timeout: with digit_count>0 and ENTRY_TIMEOUT>0, ENTRY_TIMEOUT consecutive cycles without key_valid clear digit_count and mismatch. This is not a failure: fail_count is unchanged. Every key_valid reloads the timer.
- lock_cmd and prog_cmd are ignored.

ERROR (exactly one cycle):
- error=1; fail_count increments, saturating at MAX_TRIES.
- If the new fail_count == MAX_TRIES -> LOCKOUT; else -> ENTRY.
- key_valid is ignored.

LOCKOUT:
- Timer loads LOCKOUT_CYCLES on entry and counts down.
- key_valid and commands are ignored.
- When the timer reaches 0 -> ENTRY, fail_count:=0.
- Duration is exactly LOCKOUT_CYCLES cycles of lockout=1.

UNLOCKED:
- unlock=1; key_valid is ignored.
- lock_cmd -> ENTRY.
- prog_cmd -> PROGRAM with digit_count:=0.
- lock_cmd wins over prog_cmd when both are asserted.

PROGRAM:
- Each key_valid writes key_digit into shadow digit[digit_count] and increments digit_count.
- On the N_DIGITS-th digit, code_reg:=shadow atomically (same clock edge) -> UNLOCKED.
- lock_cmd aborts: code_reg unchanged -> ENTRY.
- lock_cmd together with the final digit: the abort wins and the code is unchanged.
- No timeout in PROGRAM.

Encoding: unused state encodings 5-7 recover to ENTRY on the next clock.

Decomposition:
- Shared include/package lock_pkg holds:
  - state encodings (LK_ENTRY..LK_PROGRAM);
  - the state width constant;
  - a digit-slice index helper function.
- One natural sub-module, lock_timer: loadable down-counter with load/enable/zero flag, instantiated twice:
  - lockout, width $clog2(LOCKOUT_CYCLES+1);
  - entry timeout, width $clog2(ENTRY_TIMEOUT+1).
- Digit compare, code register and shadow register stay in the top level.

Test Plan:
All scenarios use the defaults (code 1,2,3,4).
1. Digits 1,2,3,4 -> unlock=1 the cycle after the 4th strobe; fail_count=0; error never pulses.
2. Digits 1,9,3,4 -> no indication after the 2nd digit; error pulses one cycle after the 4th strobe; fail_count=1; state returns to ENTRY.
3. Three wrong codes -> third error pulse, then lockout=1 for exactly 16 cycles. Correct code entered during lockout has no effect. Afterwards ENTRY with fail_count=0, and 1,2,3,4 unlocks.
4. Digits 1,2 then 32 idle cycles -> digit_count returns to 0 and fail_count unchanged. Then 1,2,3,4 unlocks.
5. Unlocked, prog_cmd, digits 5,6,7,8 -> UNLOCKED. lock_cmd -> ENTRY. 1,2,3,4 gives error; 5,6,7,8 unlocks.
6. PROGRAM with 5,6 entered, then lock_cmd -> ENTRY, code still 1,2,3,4. Separately: reset=0 asserted mid-entry -> all outputs 0 immediately (asynchronously), code back to RESET_CODE.
